// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and default constants for the reset sequencer.
//   seq_state_e : sequencer FSM state (SEQ while releasing, DONE when all released)
//   N_CH_DEF    : default number of sequenced reset channels
//   DELAY_DEF   : default clock cycles between successive channel releases
package rst_seq_pkg;

    localparam int unsigned N_CH_DEF  = 4;
    localparam int unsigned DELAY_DEF = 5;

    typedef enum logic {
        SEQ  = 1'b0,
        DONE = 1'b1
    } seq_state_e;

endpackage : rst_seq_pkg

// File: rtl/rst_seq_timer.sv
// rst_seq_timer: step counter that paces channel releases.
//   Counts 0..DELAY-1 while en is high, clearing itself after the terminal
//   value, so it never wraps past DELAY-1.
// Ports:
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset, clears the count
//   clr   in  : synchronous clear (has priority over en)
//   en    in  : advance the count on this edge
//   tc_c  out : combinational terminal-count flag (count == DELAY-1)
module rst_seq_timer #(
    parameter int unsigned DELAY = rst_seq_pkg::DELAY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(DELAY + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_c = (cnt_q == CW'(DELAY - 1));

    // Next count: clear wins, otherwise advance and fold back at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : rst_seq_timer

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases N_CH active-low resets one at a time, DELAY cycles
//   apart, bit 0 first. start restarts the whole sequence; hold freezes it.
// Ports:
//   clk      in  : clock, all state updates on posedge
//   rst_n    in  : asynchronous active-low reset, aborts and restarts sequence
//   start    in  : restart request (wins over hold)
//   hold     in  : freezes step counter, channel index and outputs
//   ch_rst_n out : per-channel active-low resets, N_CH bits
//   busy     out : sequence in progress
//   done     out : all channels released
// Optional build macro RST_SEQ_ASSERT_EN adds concurrent assertions.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned DELAY = DELAY_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            hold,
    output logic [N_CH-1:0] ch_rst_n,
    output logic            busy,
    output logic            done
);

    localparam int unsigned IW = $clog2(N_CH + 1);

    seq_state_e      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N_CH-1:0] ch_q, ch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timer_clr_c;
    logic            timer_en_c;
    logic            tc_c;

    rst_seq_timer #(
        .DELAY (DELAY)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr_c),
        .en    (timer_en_c),
        .tc_c  (tc_c)
    );

    // Next-state and output decode; start overrides everything, hold only
    // matters while sequencing
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timer_clr_c = 1'b0;
        timer_en_c  = 1'b0;

        if (start) begin
            state_d     = SEQ;
            idx_d       = '0;
            ch_d        = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            timer_clr_c = 1'b1;
        end else begin
            case (state_q)
                SEQ: begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    if (!hold) begin
                        timer_en_c = 1'b1;
                        if (tc_c) begin
                            for (int unsigned i = 0; i < N_CH; i++) begin
                                if (idx_q == IW'(i)) begin
                                    ch_d[i] = 1'b1;
                                end
                            end
                            idx_d = idx_q + IW'(1);
                            // Last channel: finish on the same edge
                            if (idx_q == IW'(N_CH - 1)) begin
                                state_d = DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = SEQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ;
            idx_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ch_rst_n = ch_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef RST_SEQ_ASSERT_EN
    // Sticky flag: any hold/start since reset invalidates the fixed-latency check
    logic disturbed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disturbed_q <= 1'b0;
        end else if (hold || start) begin
            disturbed_q <= 1'b1;
        end
    end

    // First edge after reset is the only point where busy and done are both low
    a_ch0_after_reset: assert property (@(posedge clk) disable iff (!rst_n)
        (!busy && !done) |-> nexttime[DELAY] (ch_rst_n[0] || disturbed_q));

    // Released channels always form a contiguous run starting at bit 0
    a_release_order: assert property (@(posedge clk) disable iff (!rst_n)
        ((ch_rst_n & (ch_rst_n + N_CH'(1))) == '0));

    // Without a restart, a released channel never goes back into reset
    a_no_rereset: assert property (@(posedge clk) disable iff (!rst_n)
        !start |=> ((ch_rst_n & $past(ch_rst_n)) == $past(ch_rst_n)));

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && done));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (hold && !start) |=> $stable(ch_rst_n));
`else
`endif

endmodule : rst_sequencer

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed bench for rst_sequencer. Instance u_dut uses the
//   default N_CH=4/DELAY=5; u_dut1 uses N_CH=1/DELAY=1. Both share clk and inputs.
module tb_rst_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       hold;
    logic [3:0] ch_rst_n;
    logic       busy;
    logic       done;
    logic [0:0] ch1_rst_n;
    logic       busy1;
    logic       done1;

    int total;
    int bad;
    int edge_n;

    rst_sequencer #(
        .N_CH  (4),
        .DELAY (5)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hold     (hold),
        .ch_rst_n (ch_rst_n),
        .busy     (busy),
        .done     (done)
    );

    rst_sequencer #(
        .N_CH  (1),
        .DELAY (1)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hold     (hold),
        .ch_rst_n (ch1_rst_n),
        .busy     (busy1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Advance one posedge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int e);
        while (edge_n < e) tick();
    endtask

    // Synchronous-looking reset pulse placed between edges; next edge is edge 1
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic chk_main(input string tag, input logic [3:0] ch, input logic b, input logic d);
        check({tag, "_ch"},   32'(ch_rst_n), 32'(ch));
        check({tag, "_busy"}, 32'(busy),     32'(b));
        check({tag, "_done"}, 32'(done),     32'(d));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        edge_n = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;

        // Reset state while rst_n is held low
        #3;
        chk_main("rst", 4'b0000, 1'b0, 1'b0);
        check("rst_dut1_ch",   32'(ch1_rst_n), 32'd0);
        check("rst_dut1_done", 32'(done1),     32'd0);

        // Plain sequence: releases at edges 5/10/15/20
        rst_n  = 1'b1;
        edge_n = 0;
        tick_to(1);
        chk_main("e1", 4'b0000, 1'b1, 1'b0);
        check("n1d1_e1_ch",   32'(ch1_rst_n), 32'd1);
        check("n1d1_e1_done", 32'(done1),     32'd1);
        check("n1d1_e1_busy", 32'(busy1),     32'd0);
        tick_to(4);
        chk_main("e4", 4'b0000, 1'b1, 1'b0);
        tick_to(5);
        chk_main("e5", 4'b0001, 1'b1, 1'b0);
        tick_to(9);
        chk_main("e9", 4'b0001, 1'b1, 1'b0);
        tick_to(10);
        chk_main("e10", 4'b0011, 1'b1, 1'b0);
        tick_to(15);
        chk_main("e15", 4'b0111, 1'b1, 1'b0);
        tick_to(19);
        chk_main("e19", 4'b0111, 1'b1, 1'b0);
        tick_to(20);
        chk_main("e20", 4'b1111, 1'b0, 1'b1);
        tick_to(24);
        chk_main("e24", 4'b1111, 1'b0, 1'b1);

        // start + hold together in DONE at edge 25; hold kept for edges 26,27
        start = 1'b1;
        hold  = 1'b1;
        tick_to(25);
        chk_main("sh_e25", 4'b0000, 1'b1, 1'b0);
        start = 1'b0;
        tick_to(27);
        chk_main("sh_e27", 4'b0000, 1'b1, 1'b0);
        hold = 1'b0;
        tick_to(31);
        chk_main("sh_e31", 4'b0000, 1'b1, 1'b0);
        tick_to(32);
        chk_main("sh_e32", 4'b0001, 1'b1, 1'b0);

        // Async reset between edges 7 and 8
        do_reset();
        tick_to(7);
        chk_main("ar_e7", 4'b0001, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("ar_async", 4'b0000, 1'b0, 1'b0);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        tick_to(1);
        chk_main("ar_e1", 4'b0000, 1'b1, 1'b0);
        tick_to(4);
        chk_main("ar_e4", 4'b0000, 1'b1, 1'b0);
        tick_to(5);
        chk_main("ar_e5", 4'b0001, 1'b1, 1'b0);

        // Restart mid-sequence at edge 12
        tick_to(11);
        chk_main("st_e11", 4'b0011, 1'b1, 1'b0);
        start = 1'b1;
        tick_to(12);
        chk_main("st_e12", 4'b0000, 1'b1, 1'b0);
        check("st_dut1_e12", 32'(ch1_rst_n), 32'd0);
        start = 1'b0;
        tick_to(13);
        check("st_dut1_e13", 32'(ch1_rst_n), 32'd1);
        check("st_dut1_done_e13", 32'(done1), 32'd1);
        tick_to(16);
        chk_main("st_e16", 4'b0000, 1'b1, 1'b0);
        tick_to(17);
        chk_main("st_e17", 4'b0001, 1'b1, 1'b0);
        tick_to(31);
        chk_main("st_e31", 4'b0111, 1'b1, 1'b0);
        tick_to(32);
        chk_main("st_e32", 4'b1111, 1'b0, 1'b1);

        // hold high for edges 3..5 shifts every release by 3
        do_reset();
        tick_to(2);
        hold = 1'b1;
        tick_to(5);
        chk_main("hd_e5", 4'b0000, 1'b1, 1'b0);
        hold = 1'b0;
        tick_to(7);
        chk_main("hd_e7", 4'b0000, 1'b1, 1'b0);
        tick_to(8);
        chk_main("hd_e8", 4'b0001, 1'b1, 1'b0);
        tick_to(12);
        chk_main("hd_e12", 4'b0001, 1'b1, 1'b0);
        tick_to(13);
        chk_main("hd_e13", 4'b0011, 1'b1, 1'b0);
        tick_to(22);
        chk_main("hd_e22", 4'b0111, 1'b1, 1'b0);
        tick_to(23);
        chk_main("hd_e23", 4'b1111, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rst_sequencer
